// File: rtl/m2_block_writer.sv
// Copies one 8x8 IDCT block from the dual-port RAM into the YUV frame in SRAM.
// Reads two samples per cycle, clips each to 8 bits, and writes one 16-bit word per cycle.
module m2_block_writer #(
    parameter logic [17:0] Y_BASE = 18'd0,
    parameter logic [17:0] U_BASE = 18'd38400,
    parameter logic [17:0] V_BASE = 18'd57600
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    input  logic [1:0]  segment,
    input  logic [5:0]  block_col,
    input  logic [4:0]  block_row,
    output logic [5:0]  RAM_address_a,
    output logic [5:0]  RAM_address_b,
    input  logic [31:0] RAM_read_data_a,
    input  logic [31:0] RAM_read_data_b,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD_IN,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  seg_q, seg_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        rd_act_q, rd_act_d;
    logic [4:0]  rd_k_q, rd_k_d;
    logic [5:0]  addr_a_q, addr_a_d;
    logic [5:0]  addr_b_q, addr_b_d;
    logic        dv_q, dv_d;
    logic [4:0]  dk_q, dk_d;
    logic        we_n_q, we_n_d;
    logic        wlast_q, wlast_d;
    logic [17:0] sa_q, sa_d;
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;

    logic        legal;
    logic        accept;
    logic [17:0] stride;
    logic [17:0] seg_base;
    logic [17:0] blk_base;

    function automatic logic [7:0] clip8(input logic [31:0] s);
        if (s[31]) begin
            return 8'd0;
        end else if (|s[30:8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    always_comb begin
        legal = (segment != 2'd3) && (block_row <= 5'd29) &&
                ((segment == 2'd0) ? (block_col <= 6'd39)
                                   : (block_col <= 6'd19));
        accept = (state_q == S_IDLE) && start && legal;
        err_d  = (state_q == S_IDLE) && start && !legal;
    end

    // Geometry comes from the latched request so a late input change cannot skew it
    always_comb begin
        case (seg_q)
            2'd0: begin
                stride   = 18'd160;
                seg_base = Y_BASE;
            end
            2'd1: begin
                stride   = 18'd80;
                seg_base = U_BASE;
            end
            default: begin
                stride   = 18'd80;
                seg_base = V_BASE;
            end
        endcase
        blk_base = seg_base
                 + ({10'd0, row_q, 3'd0} * stride)
                 + {10'd0, col_q, 2'd0};
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LEAD_IN;
                    seg_d   = segment;
                    col_d   = block_col;
                    row_d   = block_row;
                end
            end
            S_LEAD_IN: state_d = S_WRITE;
            S_WRITE: begin
                if (!we_n_q && wlast_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read side: address pair for word k, one word per cycle
    always_comb begin
        rd_act_d = rd_act_q;
        rd_k_d   = rd_k_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        if (accept) begin
            rd_act_d = 1'b1;
            rd_k_d   = 5'd0;
            addr_a_d = 6'd0;
            addr_b_d = 6'd1;
        end else if (rd_act_q) begin
            if (rd_k_q == 5'd31) begin
                rd_act_d = 1'b0;
                rd_k_d   = 5'd0;
                addr_a_d = 6'd0;
                addr_b_d = 6'd0;
            end else begin
                rd_k_d   = rd_k_q + 5'd1;
                addr_a_d = {rd_k_q + 5'd1, 1'b0};
                addr_b_d = {rd_k_q + 5'd1, 1'b1};
            end
        end
    end

    // Write side: RAM data arrives one cycle after its address
    always_comb begin
        dv_d    = rd_act_q;
        dk_d    = rd_k_q;
        we_n_d  = 1'b1;
        wlast_d = 1'b0;
        sa_d    = 18'd0;
        wd_d    = 16'd0;
        if (dv_q) begin
            we_n_d  = 1'b0;
            wlast_d = (dk_q == 5'd31);
            sa_d    = blk_base
                    + ({15'd0, dk_q[4:2]} * stride)
                    + {16'd0, dk_q[1:0]};
            wd_d    = {clip8(RAM_read_data_a), clip8(RAM_read_data_b)};
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            seg_q    <= 2'd0;
            col_q    <= 6'd0;
            row_q    <= 5'd0;
            rd_act_q <= 1'b0;
            rd_k_q   <= 5'd0;
            addr_a_q <= 6'd0;
            addr_b_q <= 6'd0;
            dv_q     <= 1'b0;
            dk_q     <= 5'd0;
            we_n_q   <= 1'b1;
            wlast_q  <= 1'b0;
            sa_q     <= 18'd0;
            wd_q     <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rd_act_q <= rd_act_d;
            rd_k_q   <= rd_k_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            dv_q     <= dv_d;
            dk_q     <= dk_d;
            we_n_q   <= we_n_d;
            wlast_q  <= wlast_d;
            sa_q     <= sa_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    assign RAM_address_a   = addr_a_q;
    assign RAM_address_b   = addr_b_q;
    assign SRAM_address    = sa_q;
    assign SRAM_write_data = wd_q;
    assign SRAM_we_n       = we_n_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FINISH);
    assign err             = err_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// Bench for m2_block_writer: cycle-indexed expectation tables filled from
// the block geometry rules, checked every cycle, plus literal spot checks.
module tb_m2_block_writer;

    localparam int NC = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  segment;
    logic [5:0]  block_col;
    logic [4:0]  block_row;
    logic [5:0]  RAM_address_a, RAM_address_b;
    logic [31:0] rd_a, rd_b;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n, busy, done, err;

    logic [31:0] ram [64];

    int cyc = 0;

    bit          exp_we   [NC];
    int          exp_addr [NC];
    logic [15:0] exp_data [NC];
    bit          exp_busy [NC];
    bit          exp_done [NC];
    bit          exp_err  [NC];

    bit          cap_we   [NC];
    bit          cap_err  [NC];
    logic [17:0] cap_addr [NC];
    logic [15:0] cap_data [NC];

    int n_chk = 0;
    int n_pass = 0;
    int busy_end = -1;

    m2_block_writer dut (
        .CLOCK_50_I      (clk),
        .Resetn          (rst_n),
        .start           (start),
        .segment         (segment),
        .block_col       (block_col),
        .block_row       (block_row),
        .RAM_address_a   (RAM_address_a),
        .RAM_address_b   (RAM_address_b),
        .RAM_read_data_a (rd_a),
        .RAM_read_data_b (rd_b),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_a <= ram[RAM_address_a];
        rd_b <= ram[RAM_address_b];
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [7:0] clipm(input logic signed [31:0] v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Fill the expectation tables for a request issued in cycle t
    task automatic model_start(input int t, input int seg,
                               input int col, input int row);
        int lim, base, s, c;
        if (t <= busy_end) return;
        lim = (seg == 0) ? 39 : 19;
        if (seg > 2 || row > 29 || col > lim) begin
            exp_err[t+1] = 1'b1;
            return;
        end
        base = (seg == 0) ? 0 : (seg == 1) ? 38400 : 57600;
        s = (seg == 0) ? 160 : 80;
        for (int k = 0; k < 32; k++) begin
            c = t + 3 + k;
            exp_we[c]   = 1'b1;
            exp_addr[c] = base + (8 * row + k / 4) * s + 4 * col + k % 4;
            exp_data[c] = {clipm(ram[2*k]), clipm(ram[2*k+1])};
        end
        for (int i = t + 1; i <= t + 35; i++) exp_busy[i] = 1'b1;
        exp_done[t+35] = 1'b1;
        busy_end = t + 35;
    endtask

    always @(negedge clk) begin
        if (cyc < NC) begin
            cap_we[cyc]   = !SRAM_we_n;
            cap_err[cyc]  = err;
            cap_addr[cyc] = SRAM_address;
            cap_data[cyc] = SRAM_write_data;
            check($sformatf("we_n@%0d", cyc), SRAM_we_n, !exp_we[cyc]);
            if (exp_we[cyc]) begin
                check($sformatf("addr@%0d", cyc), SRAM_address, exp_addr[cyc]);
                check($sformatf("data@%0d", cyc), SRAM_write_data,
                      exp_data[cyc]);
            end
            check($sformatf("busy@%0d", cyc), busy, exp_busy[cyc]);
            check($sformatf("done@%0d", cyc), done, exp_done[cyc]);
            check($sformatf("err@%0d", cyc), err, exp_err[cyc]);
        end
    end

    task automatic do_start(input int seg, input int col, input int row);
        segment   = 2'(seg);
        block_col = 6'(col);
        block_row = 5'(row);
        start     = 1'b1;
        model_start(cyc, seg, col, row);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t2, nw;
        rst_n     = 1'b0;
        start     = 1'b0;
        segment   = 2'd0;
        block_col = 6'd0;
        block_row = 5'd0;
        for (int i = 0; i < 64; i++) ram[i] = 32'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_addr", SRAM_address, 0);
        check("rst_data", SRAM_write_data, 0);
        check("rst_ram_a", RAM_address_a, 0);
        check("rst_ram_b", RAM_address_b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp block, Y col 0 row 0
        t = cyc;
        do_start(0, 0, 0);
        check("model_w0_addr", exp_addr[t+3], 0);
        check("model_w0_data", exp_data[t+3], 16'h0001);
        check("model_w4_addr", exp_addr[t+7], 160);
        check("model_w4_data", exp_data[t+7], 16'h0809);
        check("model_w31_addr", exp_addr[t+34], 1123);
        check("model_w31_data", exp_data[t+34], 16'h3E3F);
        wait_until(t + 36);
        check("ramp_w0_addr", cap_addr[t+3], 0);
        check("ramp_w0_data", cap_data[t+3], 16'h0001);
        check("ramp_w4_addr", cap_addr[t+7], 160);
        check("ramp_w4_data", cap_data[t+7], 16'h0809);
        check("ramp_w31_addr", cap_addr[t+34], 1123);
        check("ramp_w31_data", cap_data[t+34], 16'h3E3F);

        // Clip block, then U corner back-to-back
        ram[0] = 32'hFFFF_FFFB;
        ram[1] = 32'd300;
        ram[2] = 32'd255;
        ram[3] = 32'd0;
        ram[9] = 32'h0001_0000;
        t = cyc;
        do_start(0, 1, 2);
        wait_until(t + 36);
        check("clip_w0", cap_data[t+3], 16'h00FF);
        check("clip_w1", cap_data[t+4], 16'hFF00);
        t2 = cyc;
        check("b2b_gap", t2 - t, 36);
        do_start(1, 19, 29);
        wait_until(t2 + 36);
        check("u_first_addr", cap_addr[t2+3], 57036);
        check("u_last_addr", cap_addr[t2+34], 57599);

        t = cyc;
        do_start(0, 39, 29);
        wait_until(t + 36);
        check("y_last_addr", cap_addr[t+34], 38399);
        t = cyc;
        do_start(2, 0, 0);
        wait_until(t + 36);
        check("v_first_addr", cap_addr[t+3], 57600);

        // Illegal requests
        t = cyc; do_start(3, 0, 0);  wait_until(t + 4);
        check("ill_seg_err", cap_err[t+1], 1);
        t = cyc; do_start(0, 40, 0); wait_until(t + 4);
        check("ill_ycol_err", cap_err[t+1], 1);
        t = cyc; do_start(1, 20, 0); wait_until(t + 4);
        check("ill_ucol_err", cap_err[t+1], 1);
        t = cyc; do_start(2, 0, 30); wait_until(t + 4);
        check("ill_row_err", cap_err[t+1], 1);

        // Start while busy is ignored
        t = cyc;
        do_start(2, 5, 7);
        wait_until(t + 10);
        do_start(0, 3, 3);
        wait_until(t + 40);
        nw = 0;
        for (int i = t; i < t + 40; i++) nw += int'(cap_we[i]);
        check("busy_ignore_writes", nw, 32);

        // Reset during word 10
        t = cyc;
        do_start(0, 2, 1);
        wait_until(t + 13);
        for (int i = t + 13; i < NC; i++) begin
            exp_we[i]   = 1'b0;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
            exp_err[i]  = 1'b0;
        end
        busy_end = -1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we_n", SRAM_we_n, 1);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        do_start(1, 0, 0);
        wait_until(t + 37);
        check("post_rst_w0_addr", cap_addr[t+3], 38400);
        check("post_rst_w0_data", cap_data[t+3], 16'h00FF);
        nw = 0;
        for (int i = t; i < t + 37; i++) nw += int'(cap_we[i]);
        check("post_rst_writes", nw, 32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/m2_block_writer.md
M2_BLOCK_WRITER -- requirements
Module: m2_block_writer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter Y_BASE SHALL default to 18'd0 and give the Y segment word base.
REQ-003 Parameter U_BASE SHALL default to 18'd38400 and give the U segment word base.
REQ-004 Parameter V_BASE SHALL default to 18'd57600 and give the V segment word base.
REQ-005 CLOCK_50_I  in  1  50 MHz clock; Resetn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to write one 8x8 block.
REQ-007 segment  in  2  0=Y, 1=U, 2=V, 3=illegal; block_col  in  6  block column; block_row  in  5  block row.
REQ-008 RAM_address_a, RAM_address_b  out  6 each  embedded dual-port RAM read addresses.
REQ-009 RAM_read_data_a, RAM_read_data_b  in  32 each  signed IDCT samples, valid one cycle after the address.
REQ-010 SRAM_address  out  18; SRAM_write_data  out  16; SRAM_we_n  out  1  active-low write enable.
REQ-011 busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  one-cycle illegal-request pulse.

Function
REQ-012 The FSM SHALL have states IDLE, LEAD_IN, WRITE, and FINISH.
- IDLE: start=1 with legal inputs -> LEAD_IN.
- LEAD_IN: fixed one cycle -> WRITE.
- WRITE: runs while k<=31 -> FINISH.
- FINISH: fixed one cycle -> IDLE.
REQ-013 A request SHALL be legal only if segment<=2, block_row<=29, and block_col<=39 (Y) or block_col<=19 (U/V).
- On an illegal request in IDLE: err pulses high during the cycle after start is sampled.
- No RAM reads, no SRAM writes, and no done are generated.
REQ-014 Segment, block_col, and block_row SHALL be latched when start is sampled in IDLE. They SHALL NOT be resampled until the next accepted start.
REQ-015 Start SHALL be ignored while busy=1.
REQ-016 The word index k SHALL step 0..31; r=k/4, c=2*(k mod 4).
- RAM_address_a=2k (pixel r,c); RAM_address_b=2k+1 (pixel r,c+1).
REQ-017 Word stride S SHALL be 160 for Y and 80 for U/V; base B SHALL be the segment parameter.
REQ-018 SRAM_address for word k SHALL equal B + (8*block_row + r)*S + 4*block_col + k mod 4, computed without truncation below 18 bits.
REQ-019 Each sample SHALL be clipped: negative (bit 31 = 1) -> 8'd0; >255 -> 8'd255; otherwise bits [7:0].
REQ-020 SRAM_write_data SHALL equal {clip(port a), clip(port b)}.
REQ-021 Timing is measured from cycle T, the cycle in which start is sampled in IDLE.
- RAM addresses for word k are driven in cycle T+1+k.
- The registered SRAM write for word k is presented in cycle T+3+k.
- SRAM_we_n=0 for exactly 32 consecutive cycles (T+3 to T+34) and 1 at all other times.
REQ-022 busy SHALL be 1 from T+1 through T+35. done SHALL pulse in T+35 only. A new start SHALL be accepted from T+36.
REQ-023 Back-to-back blocks SHALL need no gap beyond REQ-022. Throughput SHALL be 36 cycles per block.

Reset
REQ-024 On Resetn=0, the state SHALL go to IDLE asynchronously and outputs SHALL take these values:
- SRAM_we_n=1; SRAM_address=0; SRAM_write_data=0.
- RAM addresses 0; busy=0; done=0; err=0.
REQ-025 A reset in the middle of a block SHALL abort the block immediately.
- No further SRAM writes and no done are issued.
- After release, the next start begins at k=0.

Verification
REQ-026 Y, col 0, row 0, RAM[i]=i -> word0 at address 0 = 16'h0001; word4 at 160 = 16'h0809; word31 at 1123 = 16'h3E3F; done at T+35.
REQ-027 Clip test: RAM[0]=-5, RAM[1]=300 -> word0 = 16'h00FF. Samples 255 and 0 -> 16'hFF00.
REQ-028 U, col 19, row 29 -> first write at 57036, last write at 57599, none at or above V_BASE.
REQ-029 Y, col 39, row 29 -> last write at 38399. V, col 0, row 0 -> first write at 57600.
REQ-030 Illegal requests (segment=3; Y col 40; U col 20; row 30) -> err pulse, SRAM_we_n stays 1, no done.
- start at T+10 of an active block -> ignored; exactly 32 writes.
REQ-031 Resetn low during word k=10 -> SRAM_we_n=1 at once, no done.
- A new start then gives a full block from word0.
